// File: rtl/lsu_if.sv
// Execute-stage request, data-memory port and register-file write-back bundle
// for the load/store unit. The unit itself uses the slave view.
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;
  logic        wb_writeEnable;

  logic        busy;
  logic        fault;

  modport slave (
    input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output wb_write_reg, wb_write_data, wb_writeEnable, busy, fault
  );

  modport master (
    output req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  wb_write_reg, wb_write_data, wb_writeEnable, busy, fault
  );
endinterface

// File: rtl/lsu.sv
// Single-outstanding load/store unit: byte-lane stores, aligned/extended loads,
// one-cycle register-file write pulse. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module lsu (
  input  logic clk,
  input  logic rst_n,
  lsu_if.slave bus
);
  typedef logic [31:0] word_t;
  typedef logic [4:0]  reg_addr_t;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, WB, FAULT} state_e;

  state_e    state_q, state_d;
  logic      is_store_q, is_store_d;
  logic [2:0] funct3_q, funct3_d;
  word_t     addr_q, addr_d;
  word_t     wdata_q, wdata_d;
  reg_addr_t rd_q, rd_d;
  reg_addr_t wb_reg_q, wb_reg_d;
  word_t     wb_data_q, wb_data_d;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  word_t       load_ext;
  logic [3:0]  store_strb;
  word_t       store_data;

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned;

  // Checked on the raw request so the trap decision is made at accept time.
  always_comb begin
    misaligned = 1'b0;
    if (bus.req_is_store) begin
      case (bus.req_funct3)
        3'b000:  misaligned = 1'b0;
        3'b001:  misaligned = bus.req_addr[0];
        3'b010:  misaligned = |bus.req_addr[1:0];
        default: misaligned = 1'b1;
      endcase
    end else begin
      case (bus.req_funct3)
        3'b000, 3'b100: misaligned = 1'b0;
        3'b001, 3'b101: misaligned = bus.req_addr[0];
        3'b010:         misaligned = |bus.req_addr[1:0];
        default:        misaligned = 1'b1;
      endcase
    end
  end
`endif

  always_comb begin
    byte_sel = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_sel = bus.mem_rdata[{addr_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_ext = {24'b0, byte_sel};
      3'b101:  load_ext = {16'b0, half_sel};
      default: load_ext = bus.mem_rdata;
    endcase
  end

  // Unlisted store encodings fall through to a full-word write.
  always_comb begin
    case (funct3_q)
      3'b000: begin
        store_strb = 4'b0001 << addr_q[1:0];
        store_data = {4{wdata_q[7:0]}};
      end
      3'b001: begin
        store_strb = addr_q[1] ? 4'b1100 : 4'b0011;
        store_data = {2{wdata_q[15:0]}};
      end
      default: begin
        store_strb = 4'b1111;
        store_data = wdata_q;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    wb_reg_d   = wb_reg_q;
    wb_data_d  = wb_data_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          is_store_d = bus.req_is_store;
          funct3_d   = bus.req_funct3;
          addr_d     = bus.req_addr;
          wdata_d    = bus.req_wdata;
          rd_d       = bus.req_rd;
`ifdef LSU_MISALIGN_TRAP_EN
          state_d    = misaligned ? FAULT : REQ;
`else
          state_d    = REQ;
`endif
        end
      end
      REQ: begin
        if (bus.mem_gnt) begin
          if (is_store_q) begin
            state_d = IDLE;
          end else if (bus.mem_rvalid) begin
            wb_data_d = load_ext;
            wb_reg_d  = rd_q;
            state_d   = WB;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.mem_rvalid) begin
          wb_data_d = load_ext;
          wb_reg_d  = rd_q;
          state_d   = WB;
        end
      end
      WB:      state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      is_store_q <= 1'b0;
      funct3_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      wb_reg_q   <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      wb_reg_q   <= wb_reg_d;
      wb_data_q  <= wb_data_d;
    end
  end

  // Memory-side fields come only from latched state, so they hold while mem_req waits for grant.
  assign bus.req_ready      = (state_q == IDLE);
  assign bus.busy           = (state_q != IDLE);
  assign bus.mem_req        = (state_q == REQ);
  assign bus.mem_we         = is_store_q;
  assign bus.mem_addr       = {addr_q[31:2], 2'b00};
  assign bus.mem_wstrb      = is_store_q ? store_strb : 4'b0000;
  assign bus.mem_wdata      = store_data;
  assign bus.wb_write_reg   = wb_reg_q;
  assign bus.wb_write_data  = wb_data_q;
  assign bus.wb_writeEnable = (state_q == WB) && (rd_q != '0);
`ifdef LSU_MISALIGN_TRAP_EN
  assign bus.fault          = (state_q == FAULT);
`else
  assign bus.fault          = 1'b0;
`endif
endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios plus randomized traffic against
// an arithmetic reference model of lane placement and load extension.
`timescale 1ns/1ps
module tb_lsu;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lsu_if bus();
  lsu dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad   = 0;

  int          obsReady, obsWb, obsWbCycle, obsFaults, obsReqCycles, obsGntCycle, obsRvCycle, obsIssueWait;
  logic        obsTimeout, obsUnstable, obsOverlap, obsWe;
  logic [31:0] obsAddr, obsWdata, obsWbData;
  logic [3:0]  obsStrb;
  logic [4:0]  obsWbReg;

  function automatic logic [3:0] refStrb(input logic [2:0] f, input logic [31:0] a);
    if (f == 3'd0) return 4'(1 << a[1:0]);
    if (f == 3'd1) return a[1] ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] refWdata(input logic [2:0] f, input logic [31:0] d);
    if (f == 3'd0) return 32'(d[7:0]) * 32'h0101_0101;
    if (f == 3'd1) return 32'(d[15:0]) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] refLoad(input logic [2:0] f, input logic [31:0] a, input logic [31:0] r);
    int unsigned b, h;
    b = (r >> (8 * a[1:0])) & 32'hFF;
    h = (r >> (16 * a[1])) & 32'hFFFF;
    case (f)
      3'd0:    return (b >= 128) ? b - 256 : b;
      3'd1:    return (h >= 32768) ? h - 65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return r;
    endcase
  endfunction

  // Drives one access and a memory that grants after gd request cycles and answers rvd cycles after grant.
  task automatic run_access(input logic st, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                            input logic [4:0] rd, input int gd, input int rvd, input logic [31:0] rdata);
    int cyc;
    bit granted;
    obsReady = -1; obsWb = 0; obsWbCycle = -1; obsFaults = 0; obsReqCycles = 0;
    obsGntCycle = -1; obsRvCycle = -1; obsIssueWait = 0;
    obsTimeout = 1'b0; obsUnstable = 1'b0; obsOverlap = 1'b0; obsWe = 1'b0;
    obsAddr = '0; obsWdata = '0; obsWbData = '0; obsStrb = '0; obsWbReg = '0;
    while (bus.req_ready !== 1'b1 && obsIssueWait < 50) begin
      @(posedge clk); #1; obsIssueWait++;
    end
    if (bus.req_ready !== 1'b1) begin obsTimeout = 1'b1; return; end
    bus.req_valid = 1'b1; bus.req_is_store = st; bus.req_funct3 = f;
    bus.req_addr = a; bus.req_wdata = d; bus.req_rd = rd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_addr = $urandom(); bus.req_wdata = $urandom();
    bus.req_rd = 5'($urandom_range(31)); bus.req_funct3 = 3'($urandom_range(7));
    cyc = 1; granted = 1'b0;
    while (cyc < 100) begin
      if (bus.req_ready && bus.busy) obsOverlap = 1'b1;
      if (bus.fault) obsFaults++;
      if (bus.wb_writeEnable) begin
        obsWb++; obsWbCycle = cyc; obsWbData = bus.wb_write_data; obsWbReg = bus.wb_write_reg;
      end
      if (bus.mem_req) begin
        if (obsReqCycles == 0) begin
          obsAddr = bus.mem_addr; obsStrb = bus.mem_wstrb; obsWdata = bus.mem_wdata; obsWe = bus.mem_we;
        end else if (obsAddr !== bus.mem_addr || obsStrb !== bus.mem_wstrb ||
                     obsWdata !== bus.mem_wdata || obsWe !== bus.mem_we) begin
          obsUnstable = 1'b1;
        end
        obsReqCycles++;
      end
      if (bus.req_ready) begin obsReady = cyc; break; end
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = $urandom();
      if (bus.mem_req && !granted && obsReqCycles > gd) begin
        bus.mem_gnt = 1'b1; granted = 1'b1; obsGntCycle = cyc;
        if (!st && rvd == 0) begin bus.mem_rvalid = 1'b1; bus.mem_rdata = rdata; obsRvCycle = cyc; end
      end else if (granted && !st && obsRvCycle < 0 && cyc == obsGntCycle + rvd) begin
        bus.mem_rvalid = 1'b1; bus.mem_rdata = rdata; obsRvCycle = cyc;
      end
      @(posedge clk); #1; cyc++;
    end
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
    if (obsReady < 0) obsTimeout = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if ({bus.mem_req, bus.mem_we, bus.wb_writeEnable, bus.fault, bus.busy} !== 5'b0) begin
      bad++; $display("[TB] FAIL reset_ctrl got=%b want=00000", {bus.mem_req, bus.mem_we, bus.wb_writeEnable, bus.fault, bus.busy}); end
    total++; if ({bus.mem_wstrb, bus.mem_addr, bus.mem_wdata, bus.wb_write_reg, bus.wb_write_data} !== 105'b0) begin
      bad++; $display("[TB] FAIL reset_data got=%h want=0", {bus.mem_wstrb, bus.mem_addr, bus.mem_wdata, bus.wb_write_reg, bus.wb_write_data}); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_idle got ready=%b busy=%b want ready=1 busy=0", bus.req_ready, bus.busy); end
  endtask

  task automatic test_store_lanes();
    run_access(1'b1, 3'd0, 32'h0000_1003, 32'h0000_00A5, 5'd7, 0, 0, 32'h0);
    total++; if (obsTimeout !== 1'b0) begin bad++; $display("[TB] FAIL sb_timeout got=%b want=0", obsTimeout); end
    total++; if (obsAddr !== 32'h0000_1000) begin bad++; $display("[TB] FAIL sb_addr got=%h want=00001000", obsAddr); end
    total++; if (obsStrb !== 4'b1000) begin bad++; $display("[TB] FAIL sb_strb got=%b want=1000", obsStrb); end
    total++; if (obsWdata !== 32'hA5A5_A5A5) begin bad++; $display("[TB] FAIL sb_wdata got=%h want=a5a5a5a5", obsWdata); end
    total++; if (obsWe !== 1'b1) begin bad++; $display("[TB] FAIL sb_we got=%b want=1", obsWe); end
    total++; if (obsReady !== 2) begin bad++; $display("[TB] FAIL sb_ready_cycle got=%0d want=2", obsReady); end
    total++; if (obsWb !== 0) begin bad++; $display("[TB] FAIL sb_no_wb got=%0d want=0", obsWb); end
    run_access(1'b1, 3'd1, 32'h0000_2002, 32'hCAFE_1234, 5'd3, 1, 0, 32'h0);
    total++; if ({obsStrb, obsWdata} !== {4'b1100, 32'h1234_1234}) begin
      bad++; $display("[TB] FAIL sh_hi got=%b/%h want=1100/12341234", obsStrb, obsWdata); end
    run_access(1'b1, 3'd2, 32'h0000_2004, 32'hCAFE_1234, 5'd3, 2, 0, 32'h0);
    total++; if ({obsStrb, obsWdata, obsAddr} !== {4'b1111, 32'hCAFE_1234, 32'h0000_2004}) begin
      bad++; $display("[TB] FAIL sw_word got=%b/%h/%h want=1111/cafe1234/00002004", obsStrb, obsWdata, obsAddr); end
  endtask

  task automatic test_load_extend();
    run_access(1'b0, 3'd0, 32'h0000_2001, 32'h0, 5'd5, 0, 0, 32'h0000_8000);
    total++; if (obsWbData !== 32'hFFFF_FF80) begin bad++; $display("[TB] FAIL lb_data got=%h want=ffffff80", obsWbData); end
    total++; if (obsWbReg !== 5'd5) begin bad++; $display("[TB] FAIL lb_reg got=%0d want=5", obsWbReg); end
    total++; if (obsWb !== 1) begin bad++; $display("[TB] FAIL lb_pulse got=%0d want=1", obsWb); end
    total++; if (obsWbCycle !== 2 || obsReady !== 3) begin
      bad++; $display("[TB] FAIL lb_timing got wb=%0d ready=%0d want wb=2 ready=3", obsWbCycle, obsReady); end
    total++; if (obsStrb !== 4'b0000 || obsWe !== 1'b0) begin
      bad++; $display("[TB] FAIL lb_strb got=%b we=%b want=0000 we=0", obsStrb, obsWe); end
    run_access(1'b0, 3'd4, 32'h0000_2001, 32'h0, 5'd5, 0, 0, 32'h0000_8000);
    total++; if (obsWbData !== 32'h0000_0080) begin bad++; $display("[TB] FAIL lbu_data got=%h want=00000080", obsWbData); end
    run_access(1'b0, 3'd1, 32'h0000_2002, 32'h0, 5'd6, 0, 1, 32'h9ABC_1234);
    total++; if (obsWbData !== 32'hFFFF_9ABC) begin bad++; $display("[TB] FAIL lh_data got=%h want=ffff9abc", obsWbData); end
  endtask

  task automatic test_delayed_gnt();
    run_access(1'b0, 3'd2, 32'h4000_0010, 32'h0, 5'd12, 3, 2, 32'h1357_9BDF);
    total++; if (obsReqCycles !== 4) begin bad++; $display("[TB] FAIL dg_req_cycles got=%0d want=4", obsReqCycles); end
    total++; if (obsUnstable !== 1'b0) begin bad++; $display("[TB] FAIL dg_stable got=%b want=0", obsUnstable); end
    total++; if (obsWbCycle !== 7) begin bad++; $display("[TB] FAIL dg_wb_cycle got=%0d want=7", obsWbCycle); end
    total++; if (obsReady !== 8) begin bad++; $display("[TB] FAIL dg_ready got=%0d want=8", obsReady); end
    total++; if (obsWbData !== 32'h1357_9BDF) begin bad++; $display("[TB] FAIL dg_data got=%h want=13579bdf", obsWbData); end
  endtask

  task automatic test_rd_zero();
    run_access(1'b0, 3'd2, 32'h0000_0040, 32'h0, 5'd0, 1, 1, 32'hFFFF_0000);
    total++; if (obsGntCycle !== 2) begin bad++; $display("[TB] FAIL rd0_gnt got=%0d want=2", obsGntCycle); end
    total++; if (obsWb !== 0) begin bad++; $display("[TB] FAIL rd0_no_wb got=%0d want=0", obsWb); end
    total++; if (obsReady !== 5) begin bad++; $display("[TB] FAIL rd0_ready got=%0d want=5", obsReady); end
  endtask

  task automatic test_reset_in_wait();
    int wbSeen;
    bus.req_valid = 1'b1; bus.req_is_store = 1'b0; bus.req_funct3 = 3'd2;
    bus.req_addr = 32'h0000_5000; bus.req_rd = 5'd9;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.mem_gnt = 1'b1;
    @(posedge clk); #1;
    bus.mem_gnt = 1'b0;
    total++; if (bus.busy !== 1'b1 || bus.mem_req !== 1'b0) begin
      bad++; $display("[TB] FAIL rw_in_wait got busy=%b req=%b want busy=1 req=0", bus.busy, bus.mem_req); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({bus.mem_req, bus.busy, bus.wb_writeEnable} !== 3'b000) begin
      bad++; $display("[TB] FAIL rw_async got=%b want=000", {bus.mem_req, bus.busy, bus.wb_writeEnable}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b0;
    wbSeen = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.wb_writeEnable) wbSeen++;
      @(posedge clk); #1;
    end
    total++; if (wbSeen !== 0 || bus.wb_write_data !== 32'h0) begin
      bad++; $display("[TB] FAIL rw_late_rvalid got wb=%0d data=%h want wb=0 data=0", wbSeen, bus.wb_write_data); end
  endtask

  task automatic test_misaligned();
    run_access(1'b0, 3'd2, 32'h0000_3002, 32'h0, 5'd3, 0, 0, 32'h1234_5678);
`ifdef LSU_MISALIGN_TRAP_EN
    total++; if (obsFaults !== 1 || obsReqCycles !== 0 || obsWb !== 0) begin
      bad++; $display("[TB] FAIL mis_trap got fault=%0d req=%0d wb=%0d want 1/0/0", obsFaults, obsReqCycles, obsWb); end
    total++; if (obsReady !== 2) begin bad++; $display("[TB] FAIL mis_ready got=%0d want=2", obsReady); end
`else
    total++; if (obsAddr !== 32'h0000_3000 || obsFaults !== 0) begin
      bad++; $display("[TB] FAIL mis_addr got=%h fault=%0d want=00003000 fault=0", obsAddr, obsFaults); end
    total++; if (obsWbData !== 32'h1234_5678) begin bad++; $display("[TB] FAIL mis_data got=%h want=12345678", obsWbData); end
`endif
  endtask

  task automatic test_back_to_back();
    run_access(1'b1, 3'd2, 32'h0000_0100, 32'h0BAD_F00D, 5'd1, 0, 0, 32'h0);
    total++; if (obsReady !== 2 || obsOverlap !== 1'b0) begin
      bad++; $display("[TB] FAIL b2b_store got ready=%0d overlap=%b want 2/0", obsReady, obsOverlap); end
    run_access(1'b0, 3'd5, 32'h0000_0102, 32'h0, 5'd31, 0, 0, 32'h8001_7FFE);
    total++; if (obsIssueWait !== 0 || obsReady !== 3) begin
      bad++; $display("[TB] FAIL b2b_load got wait=%0d ready=%0d want 0/3", obsIssueWait, obsReady); end
    total++; if (obsWbData !== 32'h0000_8001 || obsWbReg !== 5'd31) begin
      bad++; $display("[TB] FAIL b2b_data got=%h r%0d want=00008001 r31", obsWbData, obsWbReg); end
  endtask

  task automatic test_random();
    logic [2:0]  ldF [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    logic [2:0]  stF [4] = '{3'd0, 3'd1, 3'd2, 3'd4};
    logic        st;
    logic [2:0]  f;
    logic [31:0] a, d, r;
    logic [4:0]  rd;
    int          gd, rvd, gc, rc;
    for (int i = 0; i < 40; i++) begin
      st = 1'($urandom_range(1));
`ifdef LSU_MISALIGN_TRAP_EN
      f = st ? stF[$urandom_range(2)] : ldF[$urandom_range(4)];
`else
      f = st ? stF[$urandom_range(3)] : ldF[$urandom_range(7)];
`endif
      a = $urandom(); d = $urandom(); r = $urandom(); rd = 5'($urandom_range(31));
      gd = $urandom_range(3); rvd = $urandom_range(3);
`ifdef LSU_MISALIGN_TRAP_EN
      if (f[1:0] == 2'd1) a[0] = 1'b0;
      if (f[1:0] == 2'd2) a[1:0] = 2'b00;
`endif
      run_access(st, f, a, d, rd, gd, rvd, r);
      gc = 1 + gd;
      rc = gc + rvd;
      total++; if (obsTimeout !== 1'b0 || obsUnstable !== 1'b0 || obsOverlap !== 1'b0 || obsFaults !== 0) begin
        bad++; $display("[TB] FAIL rnd%0d_proto got to=%b unst=%b ovl=%b flt=%0d want 0/0/0/0", i, obsTimeout, obsUnstable, obsOverlap, obsFaults); end
      total++; if (obsAddr !== {a[31:2], 2'b00} || obsWe !== st) begin
        bad++; $display("[TB] FAIL rnd%0d_addr got=%h we=%b want=%h we=%b", i, obsAddr, obsWe, {a[31:2], 2'b00}, st); end
      if (st) begin
        total++; if (obsStrb !== refStrb(f, a) || obsWdata !== refWdata(f, d)) begin
          bad++; $display("[TB] FAIL rnd%0d_store got=%b/%h want=%b/%h", i, obsStrb, obsWdata, refStrb(f, a), refWdata(f, d)); end
        total++; if (obsReady !== gc + 1 || obsWb !== 0) begin
          bad++; $display("[TB] FAIL rnd%0d_st_timing got ready=%0d wb=%0d want %0d/0", i, obsReady, obsWb, gc + 1); end
      end else begin
        total++; if (obsStrb !== 4'b0000 || obsReady !== rc + 2 || obsWb !== ((rd != 0) ? 1 : 0)) begin
          bad++; $display("[TB] FAIL rnd%0d_ld_ctrl got strb=%b ready=%0d wb=%0d want 0000/%0d/%0d", i, obsStrb, obsReady, obsWb, rc + 2, (rd != 0) ? 1 : 0); end
        if (rd != 0) begin
          total++; if (obsWbData !== refLoad(f, a, r) || obsWbReg !== rd || obsWbCycle !== rc + 1) begin
            bad++; $display("[TB] FAIL rnd%0d_ld_data got=%h r%0d c%0d want=%h r%0d c%0d", i, obsWbData, obsWbReg, obsWbCycle, refLoad(f, a, r), rd, rc + 1); end
        end
      end
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_is_store = 1'b0; bus.req_funct3 = '0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_rd = '0; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    test_reset();
    test_store_lanes();
    test_load_extend();
    test_delayed_gnt();
    test_rd_zero();
    test_reset_in_wait();
    test_misaligned();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
